rx_serial_7o1: RTL

RX_SERIAL_7O1 -- requirements
Module: rx_serial_7O1

---
 rtl/rx_serial_7o1_if.sv | 29 ++
 rtl/rx_serial_7o1.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rx_serial_7o1_if.sv
`default_nettype none
// ============================================================================
// rx_serial_7o1_if : line, consumer handshake and status bundle of the 7O1 receiver (rev 1.0)
// ============================================================================
interface rx_serial_7o1_if;
  logic       dado_serial;
  logic       recebe_dado;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_stop;
  logic [3:0] db_estado;
  logic       db_tick;
  logic       db_dado_serial;

  modport master (
    output dado_serial, recebe_dado,
    input  dados_ascii, pronto, tem_dado, erro_paridade, erro_stop,
           db_estado, db_tick, db_dado_serial
  );

  modport slave (
    input  dado_serial, recebe_dado,
    output dados_ascii, pronto, tem_dado, erro_paridade, erro_stop,
           db_estado, db_tick, db_dado_serial
  );
endinterface
`default_nettype wire

// File: rtl/rx_serial_7o1.sv
`default_nettype none
// ============================================================================
// rx_serial_7o1 : 7 data bits, odd parity, 1 stop bit serial receiver, mid-bit sampling (rev 1.0)
// ============================================================================
module rx_serial_7o1 #(
  parameter int CICLOS_BIT = 434
) (
  input  logic             clock,
  input  logic             reset,
  rx_serial_7o1_if.slave   rx
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    START    = 4'd2,
    DADOS    = 4'd3,
    PARIDADE = 4'd4,
    STOP     = 4'd5,
    ARMAZENA = 4'd6
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(CICLOS_BIT / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CICLOS_BIT - 1);

  state_t      state;
  logic [15:0] cyc_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic        par_bit;
  logic        stop_bit;
  logic        sync1;
  logic        sync2;
  logic        vld1;
  logic        vld2;
  logic        prev_high;
  logic        fall;
  logic        sample_pt;

  // prev_high only counts a high level once the synchronizer holds real line
  // samples, so a line still low at reset release is never seen as a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      vld1      <= 1'b0;
      vld2      <= 1'b0;
      prev_high <= 1'b0;
    end else begin
      sync1     <= rx.dado_serial;
      sync2     <= sync1;
      vld1      <= 1'b1;
      vld2      <= vld1;
      prev_high <= vld2 & sync2;
    end
  end

  assign fall      = prev_high & ~sync2;
  assign sample_pt = ((state == START) && (cyc_cnt == HALF_LAST)) ||
                     (((state == DADOS) || (state == PARIDADE) || (state == STOP)) &&
                      (cyc_cnt == FULL_LAST));

  assign rx.db_tick        = sample_pt;
  assign rx.db_estado      = state;
  assign rx.db_dado_serial = sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= INICIAL;
      cyc_cnt          <= 16'd0;
      bit_cnt          <= 3'd0;
      shreg            <= 7'd0;
      par_bit          <= 1'b0;
      stop_bit         <= 1'b0;
      rx.dados_ascii   <= 7'd0;
      rx.pronto        <= 1'b0;
      rx.tem_dado      <= 1'b0;
      rx.erro_paridade <= 1'b0;
      rx.erro_stop     <= 1'b0;
    end else begin
      rx.pronto <= 1'b0;
      if (rx.recebe_dado) begin
        rx.tem_dado <= 1'b0;
      end
      case (state)
        INICIAL: state <= ESPERA;
        ESPERA: begin
          bit_cnt <= 3'd0;
          cyc_cnt <= 16'd0;
          if (fall) begin
            state <= START;
          end
        end
        START: begin
          if (sample_pt) begin
            cyc_cnt <= 16'd0;
            state   <= sync2 ? ESPERA : DADOS;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        DADOS: begin
          if (sample_pt) begin
            cyc_cnt <= 16'd0;
            shreg   <= {sync2, shreg[6:1]};
            if (bit_cnt == 3'd6) begin
              bit_cnt <= 3'd0;
              state   <= PARIDADE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        PARIDADE: begin
          if (sample_pt) begin
            cyc_cnt <= 16'd0;
            par_bit <= sync2;
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        STOP: begin
          if (sample_pt) begin
            cyc_cnt  <= 16'd0;
            stop_bit <= sync2;
            state    <= ARMAZENA;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        ARMAZENA: begin
          // the set wins over a simultaneous acknowledge (later assignment)
          rx.dados_ascii   <= shreg;
          rx.erro_paridade <= ~(^{shreg, par_bit});
          rx.erro_stop     <= ~stop_bit;
          rx.pronto        <= 1'b1;
          rx.tem_dado      <= 1'b1;
          state            <= ESPERA;
        end
        default: state <= ESPERA;
      endcase
    end
  end

endmodule
`default_nettype wire
